// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue block: op-codes, flag indices, condition codes, FSM states.
// Conditional execution is compiled in with the ALU_ISSUE_CONDEXEC_EN macro (see alu_issue).
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_ROR = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    // Bit positions inside flags_q = {V,C,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_C      = 2'b10;
    localparam logic [1:0] COND_V      = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    function automatic logic op_defined(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

    function automatic logic cond_pass(input logic [1:0] cond, input logic [2:0] flags);
        logic pass;
        pass = 1'b1;
        case (cond)
            COND_ALWAYS: pass = 1'b1;
            COND_Z:      pass = flags[FLAG_Z];
            COND_C:      pass = flags[FLAG_C];
            COND_V:      pass = flags[FLAG_V];
            default:     pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x DATA_W, two operand read ports, one debug read port, one write port.
// R0 reads as zero and ignores writes.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NREGS];

    // NOTE: the storage is reset because every register must read zero after reset;
    // this rules out RAM-macro inference, which is acceptable at this depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    assign rd1      = (ra1      == '0) ? '0 : mem[ra1];
    assign rd2      = (ra2      == '0) ? '0 : mem[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Two-cycle issue/writeback wrapper around an external combinational ALU.
// Define ALU_ISSUE_CONDEXEC_EN to enable conditional execution on flags_q via instr_cond.
module alu_issue #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [2:0]        instr_rd,
    input  logic [2:0]        instr_rs1,
    input  logic [2:0]        instr_rs2,
    input  logic              instr_use_imm,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic [1:0]        instr_cond,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        flags_q,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    import alu_pkg::*;

    localparam int AW = $clog2(NREGS);

`ifdef ALU_ISSUE_CONDEXEC_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q;
    logic [3:0]        op_q;
    logic [2:0]        rd_q;
    logic [1:0]        cond_q;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              accept;
    logic              commit;

    assign instr_ready = (state_q == IDLE);
    assign accept      = instr_valid && instr_ready;

    // flags_q only moves on a commit edge, so testing it in EXEC equals testing it at accept.
    assign commit = (state_q == EXEC) && op_defined(op_q) &&
                    (!COND_EN || cond_pass(cond_q, flags_q));

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            cond_q   <= '0;
            flags_q  <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking default-then-override: the later assignment wins, giving a one-cycle pulse.
            wb_valid <= 1'b0;
            if (accept) begin
                op_q   <= instr_op;
                rd_q   <= instr_rd;
                cond_q <= instr_cond;
                a_q    <= rs1_data;
                b_q    <= instr_use_imm ? instr_imm : rs2_data;
            end
            if (commit) begin
                flags_q  <= {alu_overflow, alu_carry, alu_zero};
                wb_rd    <= rd_q;
                wb_data  <= alu_result;
                wb_valid <= 1'b1;
            end
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (instr_rs1[AW-1:0]),
        .rd1      (rs1_data),
        .ra2      (instr_rs2[AW-1:0]),
        .rd2      (rs2_data),
        .dbg_addr (dbg_addr[AW-1:0]),
        .dbg_data (dbg_data),
        .we       (commit),
        .wa       (rd_q[AW-1:0]),
        .wd       (alu_result)
    );

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small combinational ALU model on the ALU side.
// Build with ALU_ISSUE_CONDEXEC_EN defined to exercise the conditional-execution path.
module tb_alu_issue;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd, instr_rs1, instr_rs2;
    logic       instr_use_imm;
    logic [7:0] instr_imm;
    logic [1:0] instr_cond;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero, alu_carry, alu_overflow;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [2:0] flags_q;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue #(.DATA_W(8), .NREGS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rd      (instr_rd),
        .instr_rs1     (instr_rs1),
        .instr_rs2     (instr_rs2),
        .instr_use_imm (instr_use_imm),
        .instr_imm     (instr_imm),
        .instr_cond    (instr_cond),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flags_q       (flags_q),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: ADD/SUB/AND/XOR; SUB carry means borrow.
    always_comb begin
        logic [8:0] wide;
        wide         = 9'd0;
        alu_result   = 8'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'b0000: begin
                wide         = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = wide[7:0];
                alu_carry    = wide[8];
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            4'b0001: begin
                alu_result   = alu_a - alu_b;
                alu_carry    = alu_a < alu_b;
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            4'b0010: alu_result = alu_a & alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            default: alu_result = 8'd0;
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reg(input logic [2:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        check($sformatf("dbg_r%0d", addr), dbg_data, exp);
    endtask

    // Called at a negedge; returns at the negedge inside EXEC.
    task automatic offer(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic use_imm, input logic [7:0] imm,
                         input logic [1:0] cond);
        check("ready_at_offer", instr_ready, 1);
        instr_valid   = 1'b1;
        instr_op      = op;
        instr_rd      = rd;
        instr_rs1     = rs1;
        instr_rs2     = rs2;
        instr_use_imm = use_imm;
        instr_imm     = imm;
        instr_cond    = cond;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("busy_in_exec", instr_ready, 0);
    endtask

    // Advances to the negedge of the cycle in which wb_valid should be high.
    task automatic finish();
        @(posedge clk);
        @(negedge clk);
        check("ready_after_exec", instr_ready, 1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic use_imm, input logic [7:0] imm,
                         input logic [1:0] cond);
        offer(op, rd, rs1, rs2, use_imm, imm, cond);
        finish();
    endtask

    task automatic check_wb(input string tag, input logic v, input logic [2:0] rd,
                            input logic [7:0] data, input logic [2:0] flags);
        check({tag, "_wb_valid"}, wb_valid, v);
        check({tag, "_wb_rd"},    wb_rd,    rd);
        check({tag, "_wb_data"},  wb_data,  data);
        check({tag, "_flags"},    flags_q,  flags);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_op      = 4'd0;
        instr_rd      = 3'd0;
        instr_rs1     = 3'd0;
        instr_rs2     = 3'd0;
        instr_use_imm = 1'b0;
        instr_imm     = 8'd0;
        instr_cond    = 2'b00;
        dbg_addr      = 3'd0;

        repeat (2) @(negedge clk);
        check("rst_wb_valid", wb_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) check_reg(3'(i), 8'd0);
        check("rst_flags", flags_q, 3'b000);
        check("rst_ready", instr_ready, 1);

        // ADD r1 = r0 + 200; ADD r2 = r0 + 100; ADD r3 = r1 + r2 issued back-to-back on r2's writeback.
        issue(4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 8'd200, 2'b00);
        check_wb("add_r1", 1'b1, 3'd1, 8'd200, 3'b000);
        issue(4'b0000, 3'd2, 3'd0, 3'd0, 1'b1, 8'd100, 2'b00);
        check_wb("add_r2", 1'b1, 3'd2, 8'd100, 3'b000);
        issue(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, 2'b00);
        check_wb("add_r3", 1'b1, 3'd3, 8'd44, 3'b010);
        check_reg(3'd3, 8'd44);

        // Offered one cycle after the previous writeback.
        @(negedge clk);
        check("wb_pulse_one_cycle", wb_valid, 0);
        issue(4'b0001, 3'd4, 3'd1, 3'd1, 1'b0, 8'd0, 2'b00);
        check_wb("sub_r4", 1'b1, 3'd4, 8'd0, 3'b001);

        // Writes to r0 are dropped but still pulse wb_valid and update flags.
        issue(4'b0000, 3'd0, 3'd0, 3'd0, 1'b1, 8'd5, 2'b00);
        check_wb("add_r0", 1'b1, 3'd0, 8'd5, 3'b000);
        check_reg(3'd0, 8'd0);

        issue(4'b0010, 3'd5, 3'd1, 3'd0, 1'b1, 8'h0F, 2'b00);
        check_wb("and_r5", 1'b1, 3'd5, 8'd8, 3'b000);
        issue(4'b0100, 3'd6, 3'd1, 3'd2, 1'b0, 8'd0, 2'b00);
        check_wb("xor_r6", 1'b1, 3'd6, 8'd172, 3'b000);

        // rs1 == rs2 == rd uses pre-write values: 100 + 100 = 200 with signed overflow.
        issue(4'b0000, 3'd2, 3'd2, 3'd2, 1'b0, 8'd0, 2'b00);
        check_wb("add_r2_self", 1'b1, 3'd2, 8'd200, 3'b100);

        // Undefined op: no writeback, flags and registers unchanged.
        issue(4'b1111, 3'd7, 3'd1, 3'd2, 1'b0, 8'd0, 2'b00);
        check_wb("undef_op", 1'b0, 3'd2, 8'd200, 3'b100);
        check_reg(3'd7, 8'd0);
        check_reg(3'd1, 8'd200);
        check_reg(3'd2, 8'd200);
        check_reg(3'd5, 8'd8);

        // Reset in the middle of EXEC aborts ADD r5 = r0 + 9.
        offer(4'b0000, 3'd5, 3'd0, 3'd0, 1'b1, 8'd9, 2'b00);
        rst_n = 1'b0;
        #2;
        check("rst_mid_wb_valid", wb_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_wb_valid", wb_valid, 0);
        check("post_rst_flags", flags_q, 3'b000);
        check("post_rst_ready", instr_ready, 1);
        check_reg(3'd5, 8'd0);
        check_reg(3'd1, 8'd0);

        // cond = Z with Z clear.
        issue(4'b0000, 3'd6, 3'd0, 3'd0, 1'b1, 8'd7, 2'b01);
`ifdef ALU_ISSUE_CONDEXEC_EN
        check_wb("cond_skip", 1'b0, 3'd0, 8'd0, 3'b000);
        check_reg(3'd6, 8'd0);
`else
        check_wb("cond_ignored", 1'b1, 3'd6, 8'd7, 3'b000);
        check_reg(3'd6, 8'd7);
`endif

        // Set Z, then cond = Z executes in both builds.
        issue(4'b0001, 3'd0, 3'd0, 3'd0, 1'b0, 8'd0, 2'b00);
        check_wb("sub_r0", 1'b1, 3'd0, 8'd0, 3'b001);
        issue(4'b0000, 3'd7, 3'd0, 3'd0, 1'b1, 8'd3, 2'b01);
        check_wb("cond_taken", 1'b1, 3'd7, 8'd3, 3'b000);
        check_reg(3'd7, 8'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand/result width; it must match the ALU width.
REQ-002 SHALL have parameter NREGS, default 8, meaning register-file depth; the address width is log2(NREGS).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n come first.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 instr_valid  in  1  instruction offered.
REQ-007 instr_ready  out  1  block can accept.
REQ-008 instr_op  in  4  ALU op_code.
REQ-009 instr_rd / instr_rs1 / instr_rs2  in  3 each  destination and source register addresses.
REQ-010 instr_use_imm  in  1  operand b comes from instr_imm instead of rs2.
REQ-011 instr_imm  in  DATA_W  immediate value.
REQ-012 instr_cond  in  2  condition: 00 always, 01 Z set, 10 C set, 11 V set (used only with the macro in REQ-033).
REQ-013 alu_a / alu_b  out  DATA_W  operands to the ALU.
REQ-014 alu_op  out  4  op_code to the ALU.
REQ-015 alu_result  in  DATA_W, and alu_zero / alu_carry / alu_overflow  in  1 each  combinational ALU response.
REQ-016 wb_valid  out  1  one-cycle pulse marking a completed writeback.
REQ-017 wb_rd  out  3, and wb_data  out  DATA_W  writeback destination and value.
REQ-018 flags_q  out  3  registered flags {V,C,Z}.
REQ-019 dbg_addr  in  3, and dbg_data  out  DATA_W  combinational register-file read port.

Function
REQ-020 SHALL implement a two-state FSM with states IDLE and EXEC.
REQ-021 In IDLE, instr_ready SHALL be 1; in EXEC, instr_ready SHALL be 0.
REQ-022 In IDLE, when instr_valid and instr_ready are both 1 at a clock edge, the block SHALL latch op, rd and cond; latch a_q = R[rs1]; latch b_q = use_imm ? imm : R[rs2]; and go to EXEC.
REQ-023 alu_a, alu_b and alu_op SHALL be driven only from the latched registers a_q, b_q and op_q, never combinationally from instr_*.
REQ-024 On the EXEC clock edge, for ops 0000-1011, the block SHALL write alu_result to R[rd], write {overflow,carry,zero} to flags_q, load wb_rd and wb_data, and set wb_valid = 1 for exactly the next cycle; the FSM SHALL return to IDLE.
REQ-025 Latency SHALL be 2 cycles from accept to wb_valid; sustained throughput SHALL be one instruction per 2 cycles.
REQ-026 An instruction accepted in the cycle where wb_valid is high SHALL read the just-written register value; no hazard logic is required.
REQ-027 R0 SHALL always read 0; writes to R0 SHALL be discarded, but flags_q SHALL still update and wb_valid SHALL still pulse.
REQ-028 For undefined ops 1100-1111, the block SHALL not write any register, SHALL leave flags_q unchanged and SHALL keep wb_valid = 0; the FSM SHALL still pass through EXEC.
REQ-029 When rs1 == rs2 == rd, operands SHALL be the pre-write values.

Reset
REQ-030 While rst_n = 0: FSM SHALL be IDLE; all registers, flags_q, a_q, b_q, op_q, wb_rd, wb_data and wb_valid SHALL be 0; instr_ready SHALL be 1 once rst_n = 1.
REQ-031 Reset asserted during EXEC SHALL abort the instruction with no register or flag write.

Configuration
REQ-032 Macro ALU_ISSUE_CONDEXEC_EN SHALL control conditional execution.
REQ-033 With ALU_ISSUE_CONDEXEC_EN defined, an instruction whose cond tests a clear bit of flags_q (as sampled at accept) SHALL be skipped: no write, flags unchanged, wb_valid = 0, and it SHALL still take 2 cycles.
REQ-034 Without the macro, instr_cond SHALL be ignored and every instruction SHALL execute.

Structure
REQ-035 Shared package alu_pkg SHALL hold the op_code localparams (ADD 0000 ... MUL 1011), the flag bit indices, the cond encodings and the FSM state typedef.
REQ-036 The register file SHALL be sub-module alu_regfile: NREGS x DATA_W, two read ports plus the debug read port, one write port, R0 hardwired to 0.

Verification
REQ-037 Reset, then release -> dbg_data = 0 for all 8 addresses, flags_q = 000, instr_ready = 1.
REQ-038 ADD r1 = r0 + imm 200, then ADD r2 = r0 + imm 100, then ADD r3 = r1 + r2 -> wb_data = 44, wb_rd = 3, flags_q = {V0,C1,Z0}, dbg r3 = 44.
REQ-039 SUB r4 = r1 - r1 offered in the cycle after the previous wb_valid -> accepted, wb_data = 0, Z = 1; instr_ready = 0 during EXEC.
REQ-040 ADD r0 = r0 + imm 5 -> wb_valid = 1, wb_data = 5, Z = 0, dbg r0 = 0.
REQ-041 op 1111 -> wb_valid stays 0, flags_q and all registers unchanged; rst_n pulsed low mid-EXEC of ADD r5 = r0 + imm 9 -> r5 = 0.
REQ-042 With the macro, Z = 0 and cond = 01 -> skipped, no wb_valid; without the macro, the same instruction executes.
